// File: rtl/pet_io_hub_pkg.sv
// pet_io_pkg: shared FSM state, hub register map and defaults
// for the PET I/O hub.
package pet_io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT,
    DONE
  } state_t;

  localparam logic [2:0] REG_PEND = 3'd0;
  localparam logic [2:0] REG_MASK = 3'd1;
  localparam logic [2:0] REG_EDGE = 3'd2;
  localparam logic [2:0] REG_ACK  = 3'd3;
  localparam logic [2:0] REG_TMO  = 3'd4;

  localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/pet_io_hub_if.sv
// pet_io_hub_if: CPU-side bus plus peripheral slot bus
// of the PET I/O hub.
interface pet_io_hub_if #(
  parameter int NSLOT = 4
);
  logic               ce;
  logic               cs;
  logic               we;
  logic [7:0]         addr;
  logic [7:0]         data_in;
  logic [7:0]         data_out;
  logic               cpu_rdy;
  logic               irq;
  logic [NSLOT-1:0]   slot_strobe;
  logic               slot_we;
  logic [7:0]         slot_addr;
  logic [7:0]         slot_wdata;
  logic [8*NSLOT-1:0] slot_rdata;
  logic [NSLOT-1:0]   slot_ack;
  logic [NSLOT-1:0]   slot_irq;

  modport master (
    output ce, cs, we, addr, data_in,
    output slot_rdata, slot_ack, slot_irq,
    input  data_out, cpu_rdy, irq,
    input  slot_strobe, slot_we,
    input  slot_addr, slot_wdata
  );

  modport slave (
    input  ce, cs, we, addr, data_in,
    input  slot_rdata, slot_ack, slot_irq,
    output data_out, cpu_rdy, irq,
    output slot_strobe, slot_we,
    output slot_addr, slot_wdata
  );

endinterface

// File: rtl/pet_io_hub_irq.sv
// pet_irq_ctrl: per-slot mask, level/edge mode and
// W1C pending latch feeding one registered IRQ line.
module pet_irq_ctrl
  import pet_io_pkg::*;
#(
  parameter int               NSLOT    = 4,
  parameter logic [NSLOT-1:0] MASK_RST = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NSLOT-1:0] slot_irq,
  input  logic             wr,
  input  logic [2:0]       waddr,
  input  logic [NSLOT-1:0] wdata,
  output logic [NSLOT-1:0] pending,
  output logic [NSLOT-1:0] mask,
  output logic [NSLOT-1:0] edge_mode,
  output logic             irq
);

  logic [NSLOT-1:0] prev;
  logic [NSLOT-1:0] clr;
  logic [NSLOT-1:0] rise;
  logic [NSLOT-1:0] pend_d;

  assign clr  = (wr && waddr == REG_ACK) ? wdata : '0;
  assign rise = slot_irq & ~prev;
  // a fresh edge beats a simultaneous acknowledge
  assign pend_d = (edge_mode & (rise | (pending & ~clr)))
                | (~edge_mode & slot_irq);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev      <= '0;
      pending   <= '0;
      mask      <= MASK_RST;
      edge_mode <= '0;
      irq       <= 1'b0;
    end else begin
      prev    <= slot_irq;
      pending <= pend_d;
      irq     <= |(pending & mask);
      if (wr && waddr == REG_MASK) mask <= wdata;
      if (wr && waddr == REG_EDGE) edge_mode <= wdata;
    end
  end

endmodule

// File: rtl/pet_io_hub.sv
// pet_io_hub: I/O page decode onto one-hot slots with ack
// wait states, timeout flags and the interrupt controller.
module pet_io_hub
  import pet_io_pkg::*;
#(
  parameter int               NSLOT    = 4,
  parameter int               SEL_LSB  = 4,
  parameter int               TIMEOUT  = TIMEOUT_DEF,
  parameter logic [NSLOT-1:0] MASK_RST = '1
) (
  input logic         clk,
  input logic         reset_n,
  pet_io_hub_if.slave bus
);

  localparam logic [7:0] TMO_CNT = 8'(TIMEOUT);

  state_t           state_q;
  state_t           state_d;
  logic [NSLOT-1:0] sel;
  logic [NSLOT-1:0] lsel;
  logic [NSLOT-1:0] acc;
  logic [NSLOT-1:0] tmo;
  logic [NSLOT-1:0] pending;
  logic [NSLOT-1:0] mask;
  logic [NSLOT-1:0] edge_mode;
  logic [7:0]       cnt;
  logic [7:0]       dout;
  logic [7:0]       hub_rd;
  logic [7:0]       slot_rd;
  logic [7:0]       s_addr;
  logic [7:0]       s_wdata;
  logic             s_we;
  logic             rdy;
  logic             idle;
  logic             take;
  logic             hub;
  logic             hub_wr;
  logic             fin;
  logic             tmo_hit;

  assign sel     = bus.addr[SEL_LSB +: NSLOT] & {NSLOT{bus.cs}};
  assign idle    = (state_q == IDLE) || (state_q == DONE);
  assign take    = idle && bus.ce && bus.cs;
  assign hub     = take && (sel == '0);
  assign hub_wr  = hub && bus.we;
  assign fin     = (state_q == WAIT) && (acc == lsel);
  assign tmo_hit = (state_q == WAIT) && !fin && (cnt == TMO_CNT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE:
        if (bus.ce)
          state_d = !bus.cs ? IDLE
                  : (sel != '0) ? STROBE : DONE;
      STROBE:  state_d = WAIT;
      WAIT:    if (fin || tmo_hit) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hub_rd = 8'hFF;
    case (bus.addr[2:0])
      REG_PEND: hub_rd = 8'(pending);
      REG_MASK: hub_rd = 8'(mask);
      REG_EDGE: hub_rd = 8'(edge_mode);
      REG_ACK:  hub_rd = 8'h00;
      REG_TMO:  hub_rd = 8'(tmo);
      default:  hub_rd = 8'hFF;
    endcase
  end

  // unacked slots float high, as on the original wired-AND bus
  always_comb begin
    slot_rd = 8'hFF;
    for (int i = 0; i < NSLOT; i++)
      if (acc[i]) slot_rd = slot_rd & bus.slot_rdata[8*i +: 8];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dout    <= 8'hFF;
      rdy     <= 1'b1;
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      lsel    <= '0;
      acc     <= '0;
      cnt     <= '0;
      tmo     <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        s_we    <= bus.we;
        s_addr  <= bus.addr;
        s_wdata <= bus.data_in;
        lsel    <= sel;
        if (!hub) rdy <= 1'b0;
        else if (!bus.we) dout <= hub_rd;
      end
      if (state_q == STROBE) begin
        acc <= bus.slot_ack & lsel;
        cnt <= '0;
      end else if (state_q == WAIT && !fin && !tmo_hit) begin
        acc <= acc | (bus.slot_ack & lsel);
        cnt <= cnt + 8'd1;
      end
      if (fin || tmo_hit) begin
        dout <= slot_rd;
        rdy  <= 1'b1;
      end
      if (tmo_hit)
        tmo <= tmo | (lsel & ~acc);
      else if (hub_wr && bus.addr[2:0] == REG_TMO)
        tmo <= tmo & ~bus.data_in[NSLOT-1:0];
    end
  end

  assign bus.data_out    = dout;
  assign bus.cpu_rdy     = rdy;
  assign bus.slot_strobe = (state_q == STROBE) ? lsel : '0;
  assign bus.slot_we     = s_we;
  assign bus.slot_addr   = s_addr;
  assign bus.slot_wdata  = s_wdata;

  pet_irq_ctrl #(
    .NSLOT    (NSLOT),
    .MASK_RST (MASK_RST)
  ) u_irq (
    .clk       (clk),
    .reset_n   (reset_n),
    .slot_irq  (bus.slot_irq),
    .wr        (hub_wr),
    .waddr     (bus.addr[2:0]),
    .wdata     (bus.data_in[NSLOT-1:0]),
    .pending   (pending),
    .mask      (mask),
    .edge_mode (edge_mode),
    .irq       (bus.irq)
  );

endmodule

// File: tb/tb_pet_io_hub.sv
// tb_pet_io_hub: random and directed accesses checked against a
// transaction-level model of the hub and its interrupt rules.
module tb_pet_io_hub;

  localparam int N = 4;
  localparam int T = 15;
  localparam int NEVER = 1000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  pet_io_hub_if #(.NSLOT(N)) bus();

  pet_io_hub #(
    .NSLOT    (N),
    .SEL_LSB  (4),
    .TIMEOUT  (T),
    .MASK_RST (4'hF)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic         chk_en = 1'b0;
  logic         irq_rand = 1'b0;
  logic         exp_rdy, exp_irq, exp_we;
  logic [7:0]   exp_dout, exp_addr, exp_wdata;
  logic [N-1:0] exp_strobe;
  logic [N-1:0] m_pend, m_mask, m_edge, m_prev, m_tmo;
  logic         hub_go = 1'b0;
  logic         hub_we;
  logic [2:0]   hub_a;
  logic [7:0]   hub_d;
  logic [7:0]   hub_rv;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cpu_rdy", 32'(bus.cpu_rdy), 32'(exp_rdy));
      chk("slot_strobe", 32'(bus.slot_strobe), 32'(exp_strobe));
      chk("data_out", 32'(bus.data_out), 32'(exp_dout));
      chk("irq", 32'(bus.irq), 32'(exp_irq));
      if (exp_strobe != '0) begin
        chk("slot_we", 32'(bus.slot_we), 32'(exp_we));
        chk("slot_addr", 32'(bus.slot_addr), 32'(exp_addr));
        chk("slot_wdata", 32'(bus.slot_wdata), 32'(exp_wdata));
      end
    end
  end

  task automatic model_reset();
    m_pend = '0; m_mask = '1; m_edge = '0; m_prev = '0; m_tmo = '0;
    exp_rdy = 1'b1; exp_dout = 8'hFF; exp_irq = 1'b0;
    exp_strobe = '0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
  endtask

  // one clock edge; the interrupt rules are applied to what the edge saw
  task automatic tick();
    logic [N-1:0] si, clr, nmask, nedge, opend, omask;
    si = bus.slot_irq; clr = '0;
    nmask = m_mask; nedge = m_edge; opend = m_pend; omask = m_mask;
    if (hub_go) begin
      if (!hub_we) begin
        case (hub_a)
          3'd0: hub_rv = 8'(m_pend);
          3'd1: hub_rv = 8'(m_mask);
          3'd2: hub_rv = 8'(m_edge);
          3'd3: hub_rv = 8'h00;
          3'd4: hub_rv = 8'(m_tmo);
          default: hub_rv = 8'hFF;
        endcase
      end else begin
        case (hub_a)
          3'd1: nmask = hub_d[N-1:0];
          3'd2: nedge = hub_d[N-1:0];
          3'd3: clr = hub_d[N-1:0];
          3'd4: m_tmo = m_tmo & ~hub_d[N-1:0];
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
    exp_irq = |(opend & omask);
    for (int i = 0; i < N; i++)
      m_pend[i] = m_edge[i] ? ((si[i] && !m_prev[i]) || (m_pend[i] && !clr[i]))
                            : si[i];
    m_prev = si; m_mask = nmask; m_edge = nedge;
    if (irq_rand) bus.slot_irq = N'($urandom);
  endtask

  task automatic hub_access(input logic w, input logic [2:0] a,
                            input logic [7:0] d);
    bus.ce = 1'b1; bus.cs = 1'b1; bus.we = w;
    bus.addr = {4'h0, 1'($urandom), a}; bus.data_in = d;
    hub_go = 1'b1; hub_we = w; hub_a = a; hub_d = d;
    tick();
    hub_go = 1'b0;
    exp_rdy = 1'b1; exp_strobe = '0;
    if (!w) exp_dout = hub_rv;
    bus.cs = 1'b0; bus.ce = 1'($urandom); bus.addr = 8'($urandom);
  endtask

  // ak[i] is the cycle (0 = strobe cycle) in which slot i pulses ack
  task automatic slot_access(input logic [7:0] a, input logic w,
                             input logic [7:0] d, input int ak[N],
                             input logic [8*N-1:0] rd, output int low);
    logic [N-1:0] sel;
    logic [7:0]   e;
    int           mx, len;
    sel = a[4 +: N]; mx = 0; low = 0;
    for (int i = 0; i < N; i++)
      if (sel[i] && ak[i] > mx) mx = ak[i];
    len = (mx <= T) ? mx + 2 : T + 2;
    bus.ce = 1'b1; bus.cs = 1'b1; bus.we = w; bus.addr = a;
    bus.data_in = d; bus.slot_rdata = rd; bus.slot_ack = '0;
    tick();
    for (int c = 0; c < len; c++) begin
      exp_rdy = 1'b0; exp_strobe = (c == 0) ? sel : '0;
      exp_we = w; exp_addr = a; exp_wdata = d;
      if (!bus.cpu_rdy) low++;
      bus.ce = 1'($urandom); bus.cs = 1'($urandom); bus.we = 1'($urandom);
      bus.addr = 8'($urandom); bus.data_in = 8'($urandom);
      for (int i = 0; i < N; i++)
        bus.slot_ack[i] = (ak[i] == c) || (!sel[i] && 1'($urandom));
      tick();
    end
    if (!bus.cpu_rdy) low++;
    e = 8'hFF;
    for (int i = 0; i < N; i++)
      if (sel[i]) begin
        if (ak[i] <= len - 2) e = e & rd[8*i +: 8];
        else m_tmo[i] = 1'b1;
      end
    exp_rdy = 1'b1; exp_strobe = '0; exp_dout = e;
    bus.slot_ack = '0; bus.cs = 1'b0; bus.ce = 1'($urandom);
  endtask

  initial begin
    int ak[N];
    int low;
    int k;
    logic [8*N-1:0] rd;
    logic [7:0] a;

    bus.ce = 1'b0; bus.cs = 1'b0; bus.we = 1'b0; bus.addr = '0;
    bus.data_in = '0; bus.slot_rdata = '0; bus.slot_ack = '0;
    bus.slot_irq = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("rst_slot_addr", 32'(bus.slot_addr), 32'h0);
    chk("rst_slot_we", 32'(bus.slot_we), 32'h0);
    chk("rst_slot_wdata", 32'(bus.slot_wdata), 32'h0);
    chk("rst_data_out", 32'(bus.data_out), 32'hFF);
    chk_en = 1'b1;
    tick();

    ak = '{0, NEVER, NEVER, NEVER};
    rd = {8'h11, 8'h22, 8'h33, 8'h5A};
    slot_access(8'h12, 1'b0, 8'h00, ak, rd, low);
    chk("ack_with_strobe_dout", 32'(bus.data_out), 32'h5A);
    chk("ack_with_strobe_low", 32'(low), 32'd2);

    ak = '{NEVER, NEVER, 5, NEVER};
    rd = {8'h77, 8'hC3, 8'h00, 8'h00};
    slot_access(8'h40, 1'b0, 8'h00, ak, rd, low);
    chk("delayed_ack_low", 32'(low), 32'd7);
    chk("delayed_ack_addr", 32'(bus.slot_addr), 32'h40);
    hub_access(1'b0, 3'd4, 8'h00);
    chk("delayed_ack_no_tmo", 32'(bus.data_out), 32'h00);

    ak = '{1, 3, NEVER, NEVER};
    rd = {8'h00, 8'h00, 8'h3C, 8'hF0};
    slot_access(8'h30, 1'b0, 8'h00, ak, rd, low);
    chk("wired_and", 32'(bus.data_out), 32'h30);

    ak = '{NEVER, NEVER, NEVER, NEVER};
    rd = {8'h12, 8'h34, 8'h56, 8'h78};
    slot_access(8'h80, 1'b1, 8'hA5, ak, rd, low);
    chk("timeout_low", 32'(low), 32'd17);
    chk("timeout_dout", 32'(bus.data_out), 32'hFF);
    hub_access(1'b0, 3'd4, 8'h00);
    chk("tmo_flag", 32'(bus.data_out), 32'h08);
    hub_access(1'b1, 3'd4, 8'h08);
    hub_access(1'b0, 3'd4, 8'h00);
    chk("tmo_clear", 32'(bus.data_out), 32'h00);

    hub_access(1'b1, 3'd2, 8'h01);
    bus.slot_irq = 4'b0001;
    tick();
    bus.slot_irq = 4'b0000;
    repeat (3) tick();
    chk("edge_irq_hold", 32'(bus.irq), 32'h1);
    hub_access(1'b1, 3'd3, 8'h01);
    tick();
    chk("edge_ack_clears", 32'(bus.irq), 32'h0);
    bus.slot_irq = 4'b0001;
    hub_access(1'b1, 3'd3, 8'h01);
    hub_access(1'b0, 3'd0, 8'h00);
    chk("edge_set_wins", 32'(bus.data_out), 32'h01);
    bus.slot_irq = 4'b0000;
    hub_access(1'b1, 3'd3, 8'h01);
    hub_access(1'b1, 3'd2, 8'h00);

    bus.slot_irq = 4'b0010;
    hub_access(1'b1, 3'd1, 8'hFD);
    repeat (3) tick();
    chk("level_masked", 32'(bus.irq), 32'h0);
    hub_access(1'b1, 3'd1, 8'hFF);
    repeat (2) tick();
    chk("level_unmasked", 32'(bus.irq), 32'h1);

    bus.ce = 1'b1; bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 8'h80;
    bus.slot_ack = '0;
    tick();
    exp_rdy = 1'b0; exp_strobe = 4'b1000;
    exp_we = 1'b0; exp_addr = 8'h80; exp_wdata = bus.data_in;
    bus.cs = 1'b0;
    tick();
    exp_strobe = '0;
    repeat (2) tick();
    chk_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_rdy", 32'(bus.cpu_rdy), 32'h1);
    chk("rst_mid_dout", 32'(bus.data_out), 32'hFF);
    chk("rst_mid_irq", 32'(bus.irq), 32'h0);
    chk("rst_mid_strobe", 32'(bus.slot_strobe), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    chk_en = 1'b1;
    tick();

    irq_rand = 1'b1;
    for (int it = 0; it < 120; it++) begin
      k = $urandom_range(0, 9);
      if (k < 4) begin
        hub_access(1'($urandom), 3'($urandom), 8'($urandom));
      end else if (k < 8) begin
        a = {4'($urandom_range(1, 15)), 4'($urandom)};
        for (int i = 0; i < N; i++) begin
          ak[i] = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 20);
          rd[8*i +: 8] = 8'($urandom);
        end
        slot_access(a, 1'($urandom), 8'($urandom), ak, rd, low);
      end else begin
        tick();
      end
    end

    irq_rand = 1'b0;
    tick();
    @(posedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pet_io_hub.md
Name: pet_io_hub

Overview:
- Parametrised successor to the PET I/O decode/mux layer.
- Decodes CPU I/O-page accesses onto NSLOT peripheral slots (PIA, VIA, CRTC, future cards), each slot one-hot selected by one address bit.
- Adds a per-slot ack handshake with wait-state insertion (cpu_rdy) and a timeout.
- Adds an interrupt controller (mask, level/edge mode, W1C pending) replacing the plain IRQ OR; sits between CPU bus and peripheral instances.

Parameters:
- NSLOT, 4, number of peripheral slots (1..8).
- SEL_LSB, 4, address bit selecting slot 0; slot i uses addr[SEL_LSB+i] (SEL_LSB+NSLOT <= 8).
- TIMEOUT, 15, clk cycles to wait for slot acks before forcing completion (1..255).
- MASK_RST, all-ones (NSLOT bits), reset value of IRQ mask.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ce  in  1  CPU cycle enable; the hub samples CPU bus only when ce=1
- cs  in  1  I/O page select (0xE8xx)
- we  in  1  CPU write
- addr  in  8  CPU address low byte
- data_in  in  8  CPU write data
- data_out  out  8  registered read data
- cpu_rdy  out  1  0 = hold CPU, access in progress
- irq  out  1  combined masked interrupt
- slot_strobe  out  NSLOT  one-clk access pulse per selected slot
- slot_we  out  1  latched we
- slot_addr  out  8  latched addr
- slot_wdata  out  8  latched data_in
- slot_rdata  in  8*NSLOT  slot i read data at [8i+7:8i]
- slot_ack  in  NSLOT  slot i access complete; may coincide with strobe
- slot_irq  in  NSLOT  raw slot interrupts, synchronous to clk, active high

Behaviour:
- Reset (async, reset_n=0): state IDLE, data_out=8'hFF, cpu_rdy=1, irq=0, slot_strobe=0, slot_we=0, slot_addr=0, slot_wdata=0, mask=MASK_RST, edge=0, pending=0, tmo=0, irq_prev=0.
- sel = addr[SEL_LSB+:NSLOT] & {NSLOT{cs}}. Hub registers are selected when cs=1 and sel==0.
- FSM states: IDLE, STROBE, WAIT, DONE.
- IDLE/DONE with ce&cs:
  - Latch we/addr/data_in/sel.
  - If sel!=0: go to STROBE, cpu_rdy<=0.
  - If hub access: perform register read/write this edge and go to DONE, cpu_rdy stays 1. Zero wait states.
- IDLE/DONE with ce&!cs: go to IDLE. data_out holds its value.
- STROBE (1 clk):
  - slot_strobe=latched sel. Multiple bits set → all addressed, as on PET.
  - Clear ack accumulator, load counter=0, go to WAIT.
  - Acks sampled in STROBE count.
- WAIT:
  - acc |= slot_ack & sel; counter++ each clk.
  - When acc==sel: data_out <= AND over i of (sel[i] ? slot_rdata[i] : FF), sampled on the completing edge. Go to DONE, cpu_rdy<=1.
  - If counter reaches TIMEOUT first: unacked selected slots contribute FF, tmo |= sel & ~acc; go to DONE, cpu_rdy<=1.
- While cpu_rdy=0, ce&cs is ignored; the CPU holds the bus.
- Hub registers (addr[2:0]; reads return 0 in bits >= NSLOT, data_out registered on access edge):
  - 0 PEND (RO): pending.
  - 1 MASK (RW).
  - 2 EDGE (RW): 1 = edge mode.
  - 3 ACK (WO): write-1-to-clear pending; reads 0.
  - 4 TMO (R/W1C): sticky timeout flags.
  - 5-7: read FF, writes ignored.
- IRQ logic, every clk regardless of ce:
  - irq_prev <= slot_irq.
  - Level bit: pending = slot_irq.
  - Edge bit: set on slot_irq & ~irq_prev; cleared by ACK W1C. Set wins over simultaneous clear.
  - irq (registered) = |(pending & mask); 1 clk latency from pending.
- Switching a bit from edge to level: pending follows the level next clk.
- Reset mid-access: returns to IDLE immediately, cpu_rdy=1, no strobe issued.

Decomposition:
- Package pet_io_pkg: FSM state enum (IDLE, STROBE, WAIT, DONE), hub register offsets (REG_PEND=0, REG_MASK=1, REG_EDGE=2, REG_ACK=3, REG_TMO=4), default TIMEOUT constant.
- One sub-module, pet_irq_ctrl: mask/edge/pending/irq logic, with write port from the hub.

Test Plan:
- Slot read, ack with strobe: NSLOT=4, ce&cs, addr=8'h12, slot0 ack in STROBE, rdata0=8'h5A → slot_strobe=4'b0001 for 1 clk; data_out=8'h5A; cpu_rdy low exactly 2 clks.
- Delayed ack: slot2 (addr 8'h40) acks 5 clks after strobe → cpu_rdy low 7 clks; slot_addr=8'h40; no timeout flag.
- Wired-AND read: addr=8'h30, rdata0=8'hF0, rdata1=8'h3C, staggered acks → data_out=8'h30.
- Timeout: slot3 never acks, TIMEOUT=15 → completion after 16 clks in WAIT; data_out=8'hFF; TMO read=8'h08; write 8'h08 to reg 4 → TMO=0.
- IRQ edge: EDGE=8'h01, pulse slot_irq[0] 1 clk → irq=1 and stays 1; write ACK=8'h01 → irq=0. Simultaneous rising edge and ACK → pending stays 1.
- Level/mask/reset: level slot_irq[1]=1 with MASK=8'hFD → irq=0; set MASK=8'hFF → irq=1. Assert reset_n=0 during WAIT → cpu_rdy=1, data_out=8'hFF, irq=0 immediately.
